// File: rtl/frame_rate_pkg.sv
// frame_rate_pkg
//   Shared definitions for the frame-rate monitor / HDMI reconfiguration slice:
//   2-bit mode codes, controller FSM state encoding and the nominal refresh
//   rates used by the classifier.
package frame_rate_pkg;

    typedef enum logic [1:0] {
        MODE_NONE  = 2'd0,
        MODE_HZ50  = 2'd1,
        MODE_HZ60  = 2'd2,
        MODE_OTHER = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_QUAL   = 2'd1,
        ST_LOCKED = 2'd2,
        ST_REQ    = 2'd3
    } state_t;

    localparam int NOM_HZ50 = 50;
    localparam int NOM_HZ60 = 60;

endpackage

// File: rtl/frame_rate_classify.sv
// frame_rate_classify
//   Pure combinational classifier of a measured refresh rate into a mode code.
//   Ports:
//     i_freq  [6:0]  measured refresh rate in Hz (0 = unknown)
//     o_class [1:0]  NONE for 0, HZ50 / HZ60 within +/-TOL_HZ, OTHER otherwise
//   Parameter:
//     TOL_HZ         band half-width around each nominal rate
module frame_rate_classify
    import frame_rate_pkg::*;
#(
    parameter int TOL_HZ = 3
) (
    input  logic [6:0] i_freq,
    output mode_t      o_class
);

    int freq;

    // The 50 Hz band is tested first so an overlap (large TOL_HZ) resolves to HZ50.
    always_comb begin
        freq    = {25'd0, i_freq};
        o_class = MODE_OTHER;
        if (i_freq == '0) begin
            o_class = MODE_NONE;
        end else if (freq >= NOM_HZ50 - TOL_HZ && freq <= NOM_HZ50 + TOL_HZ) begin
            o_class = MODE_HZ50;
        end else if (freq >= NOM_HZ60 - TOL_HZ && freq <= NOM_HZ60 + TOL_HZ) begin
            o_class = MODE_HZ60;
        end
    end

endmodule

// File: rtl/frame_rate_ctrl.sv
// frame_rate_ctrl
//   Qualifies the measured vertical refresh rate over several frames and
//   sequences HDMI transmitter reconfiguration through a req/ack handshake.
//   Hysteresis on lock loss and a no-signal watchdog keep glitches from
//   triggering reprogramming.
//   Ports:
//     clk, reset_n           clock, synchronous active-low reset
//     i_frame                one-cycle frame-end strobe
//     i_freq, i_freq_valid   measured refresh rate (Hz) and its qualifier
//     o_mode                 currently applied mode
//     o_locked               mode qualified and applied
//     o_cfg_req, o_cfg_mode  reconfiguration request and requested mode
//     i_cfg_ack              sequencer accepted the request
//   Optional (macro FRAME_RATE_CTRL_IRQ_EN):
//     o_irq                  sticky flag, set on any o_mode change
//     i_irq_clr              clears o_irq (a simultaneous set wins)
module frame_rate_ctrl
    import frame_rate_pkg::*;
#(
    parameter int unsigned STABLE_FRAMES  = 8,
    parameter int unsigned LOSS_FRAMES    = 4,
    parameter int          TOL_HZ         = 3,
    parameter int unsigned TIMEOUT_CYCLES = 8388608
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_frame,
    input  logic [6:0] i_freq,
    input  logic       i_freq_valid,
    output logic [1:0] o_mode,
    output logic       o_locked,
    output logic       o_cfg_req,
    output logic [1:0] o_cfg_mode,
    input  logic       i_cfg_ack
`ifdef FRAME_RATE_CTRL_IRQ_EN
    ,
    output logic       o_irq,
    input  logic       i_irq_clr
`endif
);

    localparam int unsigned CNT_W  = $clog2(STABLE_FRAMES + 1);
    localparam int unsigned MISS_W = $clog2(LOSS_FRAMES + 1);
    localparam int unsigned WD_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_FRAMES);
    localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(LOSS_FRAMES);
    localparam logic [WD_W-1:0]   WD_MAX   = WD_W'(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q,    state_d;
    mode_t             cand_q,     cand_d;
    mode_t             mode_q,     mode_d;
    mode_t             cfg_mode_q, cfg_mode_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [MISS_W-1:0] miss_q,     miss_d;
    logic [WD_W-1:0]   wdog_q,     wdog_d;
    logic              locked_q,   locked_d;
    logic              req_q,      req_d;

    mode_t             cls;
    logic              frame_ok;
    logic              wd_expire;
    logic              try_qual;
    logic [CNT_W-1:0]  qual_cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [MISS_W-1:0] miss_inc;

    frame_rate_classify #(
        .TOL_HZ (TOL_HZ)
    ) u_classify (
        .i_freq  (i_freq),
        .o_class (cls)
    );

    assign frame_ok  = i_frame & i_freq_valid;
    // An accepted frame in the same cycle clears the watchdog, so it wins.
    assign wd_expire = !frame_ok && (wdog_q >= WD_LAST);
    assign cnt_inc   = (cnt_q  == CNT_MAX)  ? cnt_q  : cnt_q  + CNT_W'(1);
    assign miss_inc  = (miss_q == MISS_MAX) ? miss_q : miss_q + MISS_W'(1);

    // State / data registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cand_q     <= MODE_NONE;
            mode_q     <= MODE_NONE;
            cfg_mode_q <= MODE_NONE;
            cnt_q      <= '0;
            miss_q     <= '0;
            wdog_q     <= '0;
            locked_q   <= 1'b0;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            mode_q     <= mode_d;
            cfg_mode_q <= cfg_mode_d;
            cnt_q      <= cnt_d;
            miss_q     <= miss_d;
            wdog_q     <= wdog_d;
            locked_q   <= locked_d;
            req_q      <= req_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        mode_d     = mode_q;
        cfg_mode_d = cfg_mode_q;
        cnt_d      = cnt_q;
        miss_d     = miss_q;
        locked_d   = locked_q;
        req_d      = req_q;
        try_qual   = 1'b0;
        qual_cnt   = '0;

        if (state_q == ST_REQ || frame_ok) begin
            wdog_d = '0;
        end else if (wdog_q != WD_MAX) begin
            wdog_d = wdog_q + WD_W'(1);
        end else begin
            wdog_d = wdog_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_ok && cls != MODE_NONE) begin
                    cand_d   = cls;
                    qual_cnt = CNT_W'(1);
                    try_qual = 1'b1;
                end
            end
            ST_QUAL: begin
                if (frame_ok) begin
                    if (cls == MODE_NONE) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cls != cand_q) begin
                        cand_d   = cls;
                        qual_cnt = CNT_W'(1);
                        try_qual = 1'b1;
                    end else begin
                        qual_cnt = cnt_inc;
                        try_qual = 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                if (frame_ok) begin
                    if (cls == mode_q) begin
                        miss_d = '0;
                    end else if (miss_inc == MISS_MAX) begin
                        locked_d = 1'b0;
                        miss_d   = '0;
                        if (cls == MODE_NONE) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_QUAL;
                            cand_d  = cls;
                            cnt_d   = CNT_W'(1);
                        end
                    end else begin
                        miss_d = miss_inc;
                    end
                end
            end
            ST_REQ: begin
                if (i_cfg_ack) begin
                    req_d    = 1'b0;
                    mode_d   = cfg_mode_q;
                    locked_d = 1'b1;
                    miss_d   = '0;
                    state_d  = ST_LOCKED;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Shared by IDLE and QUAL: a candidate that reaches STABLE_FRAMES either
        // re-locks to the already applied mode or requests reprogramming.
        if (try_qual) begin
            state_d = ST_QUAL;
            cnt_d   = qual_cnt;
            if (qual_cnt == CNT_MAX) begin
                miss_d = '0;
                if (cand_d == mode_q) begin
                    state_d  = ST_LOCKED;
                    locked_d = 1'b1;
                end else begin
                    state_d    = ST_REQ;
                    req_d      = 1'b1;
                    cfg_mode_d = cand_d;
                end
            end
        end

        if (wd_expire && state_q != ST_REQ) begin
            state_d  = ST_IDLE;
            mode_d   = MODE_NONE;
            locked_d = 1'b0;
            cnt_d    = '0;
            miss_d   = '0;
        end
    end

    // Outputs
    always_comb begin
        o_mode     = mode_q;
        o_locked   = locked_q;
        o_cfg_req  = req_q;
        o_cfg_mode = cfg_mode_q;
    end

`ifdef FRAME_RATE_CTRL_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else if (mode_d != mode_q) begin
            irq_q <= 1'b1;
        end else if (i_irq_clr) begin
            irq_q <= 1'b0;
        end
    end

    always_comb begin
        o_irq = irq_q;
    end
`endif

endmodule

// File: tb/tb_frame_rate_ctrl.sv
// tb_frame_rate_ctrl
//   Scoreboard bench for frame_rate_ctrl with STABLE_FRAMES=4, LOSS_FRAMES=3,
//   TOL_HZ=3, TIMEOUT_CYCLES=1000. Each driven cycle may push the expected
//   outputs after its clock edge; a monitor pops and compares them.
//   Define FRAME_RATE_CTRL_IRQ_EN to also exercise o_irq / i_irq_clr.
module tb_frame_rate_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       i_frame;
    logic [6:0] i_freq;
    logic       i_freq_valid;
    logic       i_cfg_ack;
    logic [1:0] o_mode;
    logic       o_locked;
    logic       o_cfg_req;
    logic [1:0] o_cfg_mode;
`ifdef FRAME_RATE_CTRL_IRQ_EN
    logic       o_irq;
    logic       i_irq_clr;
`endif

    always #5 clk = ~clk;

    frame_rate_ctrl #(
        .STABLE_FRAMES  (4),
        .LOSS_FRAMES    (3),
        .TOL_HZ         (3),
        .TIMEOUT_CYCLES (1000)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_frame      (i_frame),
        .i_freq       (i_freq),
        .i_freq_valid (i_freq_valid),
        .o_mode       (o_mode),
        .o_locked     (o_locked),
        .o_cfg_req    (o_cfg_req),
        .o_cfg_mode   (o_cfg_mode),
        .i_cfg_ack    (i_cfg_ack)
`ifdef FRAME_RATE_CTRL_IRQ_EN
        ,
        .o_irq        (o_irq),
        .i_irq_clr    (i_irq_clr)
`endif
    );

    typedef struct {
        string tag;
        int    r;
        int    cm;
        int    lk;
        int    md;
        int    ci;
        int    irq;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   irq_ci   = 0;
    int   irq_x    = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Compare everything expected for the edge just taken.
    always begin
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq({e.tag, "/req"},    32'(o_cfg_req),  32'(e.r));
            check_eq({e.tag, "/cfgmd"},  32'(o_cfg_mode), 32'(e.cm));
            check_eq({e.tag, "/locked"}, 32'(o_locked),   32'(e.lk));
            check_eq({e.tag, "/mode"},   32'(o_mode),     32'(e.md));
`ifdef FRAME_RATE_CTRL_IRQ_EN
            if (e.ci != 0) check_eq({e.tag, "/irq"}, 32'(o_irq), 32'(e.irq));
`endif
        end
    end

    // One clock: drive inputs at the falling edge, optionally push the
    // expected outputs after the following rising edge.
    task automatic tick(input string tag, input int frm, input int f, input int vld,
                        input int ack, input int en,
                        input int r, input int cm, input int lk, input int md);
        @(negedge clk);
        i_frame      = 1'(frm);
        i_freq       = 7'(f);
        i_freq_valid = 1'(vld);
        i_cfg_ack    = 1'(ack);
        if (en != 0) sb.push_back('{tag, r, cm, lk, md, irq_ci, irq_x});
        @(posedge clk);
    endtask

    task automatic frame(input string tag, input int f,
                         input int r, input int cm, input int lk, input int md);
        tick(tag, 1, f, 1, 0, 1, r, cm, lk, md);
        tick("gap", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got time %0t expected end before it", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        reset_n      = 1'b0;
        i_frame      = 1'b0;
        i_freq       = '0;
        i_freq_valid = 1'b0;
        i_cfg_ack    = 1'b0;
`ifdef FRAME_RATE_CTRL_IRQ_EN
        i_irq_clr    = 1'b0;
`endif
        irq_ci = 1;
        irq_x  = 0;
        tick("reset", 0, 0, 0, 0, 1, 0, 0, 0, 0);
        tick("reset", 0, 0, 0, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        irq_ci = 0;

        // Qualify 50 Hz from IDLE, handshake with a late ack.
        frame("A1", 50, 0, 0, 0, 0);
        frame("A2", 51, 0, 0, 0, 0);
        frame("A3", 47, 0, 0, 0, 0);
        frame("A4", 53, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) tick("A_wait", 0, 0, 0, 0, 1, 1, 1, 0, 0);
        tick("A_ack", 0, 0, 0, 1, 1, 0, 1, 1, 1);

        // Lock hysteresis: the 50 resets the miss count.
        frame("B1", 59, 0, 1, 1, 1);
        frame("B2", 59, 0, 1, 1, 1);
        frame("B3", 50, 0, 1, 1, 1);
        frame("B4", 59, 0, 1, 1, 1);
        frame("B5", 59, 0, 1, 1, 1);
        frame("B6", 59, 0, 1, 0, 1);
        frame("B7", 59, 0, 1, 0, 1);
        frame("B8", 63, 0, 1, 0, 1);
        frame("B9", 57, 1, 2, 0, 1);
        tick("B_wait", 0, 0, 0, 0, 1, 1, 2, 0, 1);
        tick("B_ack", 0, 0, 0, 1, 1, 0, 2, 1, 2);

        // Watchdog from the ack edge; invalid frames must not restart it.
        for (int k = 1; k <= 1000; k++) begin
            tick((k == 1000) ? "E_expire" : "E_hold",
                 (k % 100 == 50) ? 1 : 0, 40, 0, 0, (k >= 999) ? 1 : 0,
                 0, 2, (k == 1000) ? 0 : 1, (k == 1000) ? 0 : 2);
        end
        tick("E_after", 0, 0, 0, 0, 1, 0, 2, 0, 0);

        // Candidate restart in QUAL.
        frame("C1", 59, 0, 2, 0, 0);
        frame("C2", 59, 0, 2, 0, 0);
        frame("C3", 50, 0, 2, 0, 0);
        frame("C4", 59, 0, 2, 0, 0);
        frame("C5", 59, 0, 2, 0, 0);
        frame("C6", 59, 0, 2, 0, 0);
        frame("C7", 59, 1, 2, 0, 0);

        // Request held with no ack: frames ignored, watchdog held.
        for (int k = 1; k <= 200; k++) begin
            tick("D_frames", (k % 10 == 0) ? 1 : 0, 50, 1, 0, (k % 10 == 0) ? 1 : 0, 1, 2, 0, 0);
        end
        for (int k = 1; k <= 1100; k++) begin
            tick("D_hold", 0, 0, 0, 0, (k % 100 == 0) ? 1 : 0, 1, 2, 0, 0);
        end
        tick("D_ack", 0, 0, 0, 1, 1, 0, 2, 1, 2);
        for (int k = 0; k < 3; k++) tick("D_locked", 0, 0, 0, 0, 1, 0, 2, 1, 2);

        // Drop lock to a new candidate, then reset mid-handshake.
        frame("F1", 50, 0, 2, 1, 2);
        frame("F2", 50, 0, 2, 1, 2);
        frame("F3", 50, 0, 2, 0, 2);
        frame("F4", 50, 0, 2, 0, 2);
        frame("F5", 50, 0, 2, 0, 2);
        frame("F6", 50, 1, 1, 0, 2);
        @(negedge clk);
        reset_n = 1'b0;
        irq_ci = 1;
        irq_x  = 0;
        tick("F_rst", 0, 0, 0, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Interrupt: set on mode change wins over a simultaneous clear.
        frame("G1", 50, 0, 0, 0, 0);
        frame("G2", 50, 0, 0, 0, 0);
        frame("G3", 50, 0, 0, 0, 0);
        frame("G4", 50, 1, 1, 0, 0);
`ifdef FRAME_RATE_CTRL_IRQ_EN
        i_irq_clr = 1'b1;
`endif
        irq_x = 1;
        tick("G_ack_clr", 0, 0, 0, 1, 1, 0, 1, 1, 1);
        irq_x = 0;
        tick("G_clr", 0, 0, 0, 0, 1, 0, 1, 1, 1);
`ifdef FRAME_RATE_CTRL_IRQ_EN
        i_irq_clr = 1'b0;
`endif
        tick("G_idle", 0, 0, 0, 0, 1, 0, 1, 1, 1);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_rate_ctrl.md
Name: frame_rate_ctrl

Overview:
- Sequences HDMI transmitter reconfiguration from the measured vertical refresh rate.
- Consumes the per-frame frequency word (7-bit Hz) and valid from the frame-frequency counter, plus a one-cycle frame strobe. Classifies each frame as none/50 Hz/60 Hz/other, qualifies the class over several frames, and issues a req/ack configuration request to the transmitter configuration sequencer.
- Applies hysteresis and a no-signal watchdog so glitches do not trigger reprogramming.

Parameters:
- STABLE_FRAMES, 8, consecutive identical-class frames required to qualify a candidate mode.
- LOSS_FRAMES, 4, consecutive mismatching frames required to drop lock.
- TOL_HZ, 3, ± tolerance around 50 and 60 for classification.
- TIMEOUT_CYCLES, 8388608, clocks with no accepted frame before declaring no signal.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- i_frame  in  1  one-cycle pulse per frame (frame-end strobe)
- i_freq  in  7  measured refresh rate in Hz (0 = unknown)
- i_freq_valid  in  1  i_freq meaningful
- o_mode  out  2  current applied mode: 0 NONE, 1 HZ50, 2 HZ60, 3 OTHER
- o_locked  out  1  mode qualified and applied
- o_cfg_req  out  1  reconfiguration request
- o_cfg_mode  out  2  mode requested; stable while o_cfg_req=1
- i_cfg_ack  in  1  sequencer accepted request

Behaviour:
- One clock. Reset is synchronous and active-low on reset_n.
- Reset values: o_mode=0, o_locked=0, o_cfg_req=0, o_cfg_mode=0, state IDLE, all counters 0. Reset mid-handshake drops o_cfg_req immediately.
- Accepted frame: i_frame=1 and i_freq_valid=1. i_frame with i_freq_valid=0 is ignored entirely, including the watchdog.
- Class c (combinational on i_freq):
  - 0 if i_freq==0.
  - 1 if |i_freq-50|<=TOL_HZ.
  - 2 if |i_freq-60|<=TOL_HZ.
  - 3 otherwise.
  - The 50 band is checked before the 60 band.
- Watchdog:
  - Counts every cycle, saturates, and clears on each accepted frame.
  - Held at 0 in REQ.
  - On reaching TIMEOUT_CYCLES in IDLE/QUAL/LOCKED: next state IDLE, o_mode<=0, o_locked<=0.
- FSM (transitions at the accepted-frame edge unless noted):
  - IDLE: on frame with c!=0, go to QUAL with cand<=c, cnt<=1. Otherwise stay.
  - QUAL:
    - c==0: go to IDLE.
    - c!=cand: cand<=c, cnt<=1.
    - c==cand: cnt++.
    - When cnt+1==STABLE_FRAMES: if cand==o_mode, go to LOCKED (o_locked<=1). Else go to REQ with o_cfg_req<=1, o_cfg_mode<=cand.
    - STABLE_FRAMES=1 qualifies on the first frame.
  - REQ:
    - Frames are ignored.
    - o_cfg_req is held until i_cfg_ack=1 is sampled. Same edge: o_cfg_req<=0, o_mode<=o_cfg_mode, o_locked<=1, go to LOCKED.
    - The request is never withdrawn except by reset.
    - i_cfg_ack outside REQ is ignored.
  - LOCKED:
    - c==o_mode: miss<=0.
    - Else miss++. When miss+1==LOSS_FRAMES: o_locked<=0, go to QUAL with cand<=c, cnt<=1. If c==0, go to IDLE instead and keep o_mode.
- Counters:
  - cnt and miss are wide enough for their parameter and never wrap.
  - cnt saturates at STABLE_FRAMES; miss saturates at LOSS_FRAMES.
- Latency: o_cfg_req rises on the clock edge sampling the qualifying frame. o_locked rises on the edge sampling i_cfg_ack.
- Simultaneous watchdog expiry and accepted frame: the frame wins (the watchdog was just cleared).

Optional Feature:
- Macro: FRAME_RATE_CTRL_IRQ_EN.
- Enabled:
  - Adds ports o_irq (out, 1) and i_irq_clr (in, 1).
  - o_irq sets sticky on any o_mode change, including the timeout to NONE.
  - o_irq clears on i_irq_clr. Set wins if both occur in the same cycle.
  - Reset value 0.
- Disabled: the ports are absent and no logic is generated.

Decomposition:
- Package frame_rate_pkg:
  - mode codes MODE_NONE/HZ50/HZ60/OTHER (2-bit).
  - FSM state encoding IDLE/QUAL/LOCKED/REQ.
  - nominal constants 50 and 60.
- Sub-module frame_rate_classify: pure combinational i_freq→class with TOL_HZ parameter, reusable by other video monitors.

Test Plan:
Bench parameters: STABLE_FRAMES=4, LOSS_FRAMES=3, TOL_HZ=3, TIMEOUT_CYCLES=1000.
- Reset → o_mode=0, o_locked=0, o_cfg_req=0. 4 frames i_freq=50 → o_cfg_req=1, o_cfg_mode=1 on 4th frame edge. Ack 5 cycles later → o_mode=1, o_locked=1, o_cfg_req=0.
- Locked at 1; frames 59,59,50,59,59,59 → miss counter resets at the 50, lock drops only after the final three 59s. Then 4 frames of 59 → request o_cfg_mode=2.
- QUAL sequence 59,59,50,59,59,59,59 → candidate restarts at the 50; request issued only after the last 4 consecutive 59s.
- In REQ, withhold ack 200 cycles and send frames of 50 → o_cfg_req stays 1, o_cfg_mode stable, no watchdog expiry. Ack → LOCKED.
- Locked at 2, stop frames for 1000 cycles → o_mode=0, o_locked=0, state IDLE. Frames with i_freq_valid=0 do not restart the watchdog.
- Assert reset_n=0 while o_cfg_req=1 → o_cfg_req=0 the next cycle. With FRAME_RATE_CTRL_IRQ_EN: the mode change sets o_irq; simultaneous i_irq_clr and a mode change leave o_irq=1.
